ddr3_dma_arb: RTL and testbench



---
 rtl/ddr3_dma_arb_if.sv | 58 +++++
 rtl/ddr3_dma_arb.sv | 139 +++++++++++++
 tb/tb_ddr3_dma_arb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ddr3_dma_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_dma_arb_if
//  Description : Bundle of requester handshakes, per-engine MIG app signals
//                and the shared MIG user command port for ddr3_dma_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ddr3_dma_arb_if #(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 30
);
    // write engine side
    logic              wr_req;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_gnt;
    logic              wr_done;
    logic [2:0]        wr_app_cmd;
    logic [ADDR_W-1:0] wr_app_addr;
    logic              wr_app_en;
    logic              wr_app_rdy;
    // read engine side
    logic              rd_req;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_gnt;
    logic              rd_done;
    logic [2:0]        rd_app_cmd;
    logic [ADDR_W-1:0] rd_app_addr;
    logic              rd_app_en;
    logic              rd_app_rdy;
    // MIG user command port
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_en;
    logic              app_rdy;
    // status
    logic              busy;

    // environment side: DMA engines and the MIG
    modport master (
        output wr_req, wr_len, wr_app_cmd, wr_app_addr, wr_app_en,
        output rd_req, rd_len, rd_app_cmd, rd_app_addr, rd_app_en,
        output app_rdy,
        input  wr_gnt, wr_done, wr_app_rdy,
        input  rd_gnt, rd_done, rd_app_rdy,
        input  app_cmd, app_addr, app_en, busy
    );

    // arbiter side
    modport slave (
        input  wr_req, wr_len, wr_app_cmd, wr_app_addr, wr_app_en,
        input  rd_req, rd_len, rd_app_cmd, rd_app_addr, rd_app_en,
        input  app_rdy,
        output wr_gnt, wr_done, wr_app_rdy,
        output rd_gnt, rd_done, rd_app_rdy,
        output app_cmd, app_addr, app_en, busy
    );
endinterface
`default_nettype wire

// File: rtl/ddr3_dma_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_dma_arb
//  Description : Shares the single DDR3 MIG user command port between the
//                write and read DMA engines. A grant lasts for a requested
//                number of accepted commands; ties alternate between sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_dma_arb #(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 30
) (
    input  logic          clk,
    input  logic          rst,
    ddr3_dma_arb_if.slave bus
);

    typedef enum logic [1:0] {
        c_IDLE    = 2'd0,
        c_GNT_WR  = 2'd1,
        c_GNT_RD  = 2'd2,
        c_RELEASE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] c_CNT_ONE = LEN_W'(1);

    state_t             r_state;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_tgt;
    logic               r_last_rd;   // 1 = read side was served last

    state_t             w_state_nxt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [LEN_W-1:0]   w_tgt_nxt;
    logic               w_last_rd_nxt;

    logic               w_granted;   // in either GNT state
    logic               w_side_rd;   // granted side is the read engine
    logic               w_zero;      // zero-length grant: no beat may pass
    logic               w_x_en;
    logic [LEN_W-1:0]   w_cnt_inc;

    logic               w_wr_gnt, w_rd_gnt, w_wr_done, w_rd_done;
    logic               w_wr_app_rdy, w_rd_app_rdy;
    logic [2:0]         w_app_cmd;
    logic [ADDR_W-1:0]  w_app_addr;
    logic               w_app_en;

    assign w_granted = (r_state == c_GNT_WR) || (r_state == c_GNT_RD);
    assign w_side_rd = (r_state == c_GNT_RD);
    assign w_zero    = (r_tgt == '0);
    assign w_x_en    = w_side_rd ? bus.rd_app_en : bus.wr_app_en;
    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    // State, beat counter, target length and fairness bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_tgt     <= '0;
            r_last_rd <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tgt     <= w_tgt_nxt;
            r_last_rd <= w_last_rd_nxt;
        end
    end

    // Arbitration, command forwarding and completion tracking
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tgt_nxt     = r_tgt;
        w_last_rd_nxt = r_last_rd;
        w_wr_gnt      = 1'b0;
        w_rd_gnt      = 1'b0;
        w_wr_done     = 1'b0;
        w_rd_done     = 1'b0;
        w_wr_app_rdy  = 1'b0;
        w_rd_app_rdy  = 1'b0;
        w_app_cmd     = 3'd0;
        w_app_addr    = '0;
        w_app_en      = 1'b0;

        case (r_state)
            c_IDLE: begin
                // read wins a tie unless it was the side served last
                if (bus.rd_req && (!bus.wr_req || !r_last_rd)) begin
                    w_state_nxt = c_GNT_RD;
                    w_tgt_nxt   = bus.rd_len;
                    w_cnt_nxt   = '0;
                end else if (bus.wr_req) begin
                    w_state_nxt = c_GNT_WR;
                    w_tgt_nxt   = bus.wr_len;
                    w_cnt_nxt   = '0;
                end
            end
            c_GNT_WR, c_GNT_RD: begin
                w_wr_gnt   = !w_side_rd;
                w_rd_gnt   = w_side_rd;
                w_app_cmd  = w_side_rd ? bus.rd_app_cmd  : bus.wr_app_cmd;
                w_app_addr = w_side_rd ? bus.rd_app_addr : bus.wr_app_addr;
                w_app_en   = w_x_en && !w_zero;
                w_wr_app_rdy = !w_side_rd && bus.app_rdy && !w_zero;
                w_rd_app_rdy = w_side_rd  && bus.app_rdy && !w_zero;
                if (w_zero) begin
                    w_state_nxt   = c_RELEASE;
                    w_last_rd_nxt = w_side_rd;
                end else if (w_x_en && bus.app_rdy) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_tgt) begin
                        w_state_nxt   = c_RELEASE;
                        w_last_rd_nxt = w_side_rd;
                    end
                end
            end
            c_RELEASE: begin
                w_wr_done   = !r_last_rd;
                w_rd_done   = r_last_rd;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign bus.wr_gnt     = w_wr_gnt;
    assign bus.rd_gnt     = w_rd_gnt;
    assign bus.wr_done    = w_wr_done;
    assign bus.rd_done    = w_rd_done;
    assign bus.wr_app_rdy = w_wr_app_rdy;
    assign bus.rd_app_rdy = w_rd_app_rdy;
    assign bus.app_cmd    = w_app_cmd;
    assign bus.app_addr   = w_app_addr;
    assign bus.app_en     = w_app_en && w_granted;
    assign bus.busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr3_dma_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_dma_arb
//  Description : Directed self-checking bench for ddr3_dma_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_dma_arb;

    localparam int LEN_W  = 16;
    localparam int ADDR_W = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ddr3_dma_arb_if #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

    ddr3_dma_arb #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_req = 1'b0; bus.wr_len = '0; bus.wr_app_cmd = 3'd0;
        bus.wr_app_addr = '0; bus.wr_app_en = 1'b0;
        bus.rd_req = 1'b0; bus.rd_len = '0; bus.rd_app_cmd = 3'd0;
        bus.rd_app_addr = '0; bus.rd_app_en = 1'b0;
        bus.app_rdy = 1'b0;
    endtask

    initial begin
        logic [5:0] rdy_pat;
        logic [2:0] order;
        rdy_pat = 6'b101001;   // bit i = app_rdy in cycle i: 1,0,0,1,0,1
        order   = 3'b101;      // bit k = 1 -> read expected on k-th grant
        idle_inputs();

        // ---------------- reset values ----------------
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_wr_gnt", 64'(bus.wr_gnt), 64'd0);
        chk("rst_rd_gnt", 64'(bus.rd_gnt), 64'd0);
        chk("rst_busy",   64'(bus.busy),   64'd0);
        chk("rst_app_en", 64'(bus.app_en), 64'd0);
        chk("rst_app_cmd", 64'(bus.app_cmd), 64'd0);
        chk("rst_app_addr", 64'(bus.app_addr), 64'd0);

        // ---------------- single read, len 4 ----------------
        bus.rd_req = 1'b1; bus.rd_len = 16'd4; bus.rd_app_en = 1'b1;
        bus.rd_app_cmd = 3'd1; bus.rd_app_addr = 30'h100; bus.app_rdy = 1'b1;
        bus.wr_app_cmd = 3'd0; bus.wr_app_addr = 30'h3ff; bus.wr_app_en = 1'b1;
        #1;
        chk("rd1_gnt_latency", 64'(bus.rd_gnt), 64'd0);
        tick();
        bus.rd_req = 1'b0;   // dropping req must not end the grant
        for (int i = 0; i < 4; i++) begin
            bus.rd_app_addr = 30'h100 + 30'(i);
            #1;
            chk("rd1_gnt", 64'(bus.rd_gnt), 64'd1);
            chk("rd1_app_en", 64'(bus.app_en), 64'd1);
            chk("rd1_app_addr", 64'(bus.app_addr), 64'h100 + 64'(i));
            chk("rd1_app_cmd", 64'(bus.app_cmd), 64'd1);
            chk("rd1_rd_rdy", 64'(bus.rd_app_rdy), 64'd1);
            chk("rd1_wr_rdy", 64'(bus.wr_app_rdy), 64'd0);
            chk("rd1_done_early", 64'(bus.rd_done), 64'd0);
            tick();
        end
        bus.rd_app_en = 1'b0; bus.wr_app_en = 1'b0;
        #1;
        chk("rd1_done", 64'(bus.rd_done), 64'd1);
        chk("rd1_rel_gnt", 64'(bus.rd_gnt), 64'd0);
        chk("rd1_rel_busy", 64'(bus.busy), 64'd1);
        chk("rd1_rel_app_en", 64'(bus.app_en), 64'd0);
        tick();
        chk("rd1_idle_busy", 64'(bus.busy), 64'd0);
        chk("rd1_done_pulse", 64'(bus.rd_done), 64'd0);

        // ---------------- simultaneous requests, alternating ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.wr_req = 1'b1; bus.wr_len = 16'd2; bus.wr_app_en = 1'b1;
        bus.wr_app_cmd = 3'd0; bus.wr_app_addr = 30'h200;
        bus.rd_req = 1'b1; bus.rd_len = 16'd2; bus.rd_app_en = 1'b1;
        bus.rd_app_cmd = 3'd1; bus.rd_app_addr = 30'h300;
        bus.app_rdy = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("tie_rd_gnt", 64'(bus.rd_gnt), 64'(order[k]));
            chk("tie_wr_gnt", 64'(bus.wr_gnt), 64'(!order[k]));
            chk("tie_app_addr", 64'(bus.app_addr), order[k] ? 64'h300 : 64'h200);
            tick(); tick();
            chk("tie_rd_done", 64'(bus.rd_done), 64'(order[k]));
            chk("tie_wr_done", 64'(bus.wr_done), 64'(!order[k]));
            tick();
            chk("tie_idle_gnt", 64'({bus.rd_gnt, bus.wr_gnt}), 64'd0);
        end
        idle_inputs();
        bus.wr_app_addr = 30'h200;

        // ---------------- write with backpressure, len 3 ----------------
        bus.wr_req = 1'b1; bus.wr_len = 16'd3; bus.wr_app_en = 1'b1;
        bus.rd_app_en = 1'b1; bus.rd_app_addr = 30'h3ab;
        tick();
        bus.wr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.app_rdy = rdy_pat[i];
            #1;
            chk("bp_wr_gnt", 64'(bus.wr_gnt), 64'd1);
            chk("bp_wr_rdy", 64'(bus.wr_app_rdy), 64'(rdy_pat[i]));
            chk("bp_rd_rdy", 64'(bus.rd_app_rdy), 64'd0);
            chk("bp_app_addr", 64'(bus.app_addr), 64'h200);
            chk("bp_done_early", 64'(bus.wr_done), 64'd0);
            tick();
        end
        chk("bp_wr_done", 64'(bus.wr_done), 64'd1);
        chk("bp_rd_done", 64'(bus.rd_done), 64'd0);
        idle_inputs();
        tick();

        // ---------------- zero-length read ----------------
        bus.rd_req = 1'b1; bus.rd_len = 16'd0; bus.rd_app_en = 1'b1;
        bus.app_rdy = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        #1;
        chk("z_rd_gnt", 64'(bus.rd_gnt), 64'd1);
        chk("z_rd_rdy", 64'(bus.rd_app_rdy), 64'd0);
        chk("z_app_en", 64'(bus.app_en), 64'd0);
        tick();
        chk("z_rd_done", 64'(bus.rd_done), 64'd1);
        chk("z_rd_gnt_rel", 64'(bus.rd_gnt), 64'd0);
        idle_inputs();
        tick();
        chk("z_idle_busy", 64'(bus.busy), 64'd0);

        // ---------------- reset mid-write, then full retry ----------------
        bus.wr_req = 1'b1; bus.wr_len = 16'd5; bus.wr_app_en = 1'b1;
        bus.wr_app_addr = 30'h55; bus.app_rdy = 1'b1;
        tick();
        chk("mr_wr_gnt", 64'(bus.wr_gnt), 64'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("mr_wr_gnt_rst", 64'(bus.wr_gnt), 64'd0);
        chk("mr_app_en_rst", 64'(bus.app_en), 64'd0);
        chk("mr_busy_rst", 64'(bus.busy), 64'd0);
        chk("mr_done_rst", 64'(bus.wr_done), 64'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("mr2_wr_gnt", 64'(bus.wr_gnt), 64'd1);
            chk("mr2_wr_done_early", 64'(bus.wr_done), 64'd0);
            tick();
        end
        chk("mr2_wr_done", 64'(bus.wr_done), 64'd1);
        idle_inputs();
        tick();
        chk("mr2_idle_busy", 64'(bus.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
